systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
//  Transmit side of the 4x4 systolic multiplier's edge interface. Holds operand
//  matrices A and B, then drives the diagonal-skewed row streams (left edge) and
//  column streams (top edge) the array consumes. Clears the array before each
//  run, waits for the pipeline to drain, and pulses done_o when the array's
//  accumulators hold C = A*B. Sits between the host/load logic and the array.
// PARAMETERS
//  DW            32  element width of A, B and all stream outputs
//  FLUSH_CYCLES  4   idle (zero-driven) cycles after last beat before done_o
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   asynchronous, active-high reset
//  wr_en_i        in   1   write one matrix element this cycle
//  wr_sel_i       in   1   0 = matrix A, 1 = matrix B
//  wr_addr_i      in   4   element index row*4+col
//  wr_data_i      in   DW  element value
//  start_i        in   1   request a multiply run
//  busy_o         out  1   run in progress (CLEAR/STREAM/FLUSH)
//  done_o         out  1   one-cycle pulse, results valid in array
//  array_rst_no   out  1   active-low clear to array PEs
//  left_o_0..3    out  DW  to array left edge, row r stream (A rows)
//  up_o_0..3      out  DW  to array top edge, column c stream (B columns)
// BEHAVIOUR
//  Reset: FSM=IDLE; busy_o=0, done_o=0, array_rst_no=0, all left/up = 0;
//   A and B storage cleared to 0. array_rst_no rises to 1 on the first clock
//   after rst_i deasserts. Reset mid-run aborts immediately, same values.
//  Storage: write accepted only in IDLE (incl. the DONE cycle is not IDLE);
//   writes while busy_o=1 or done_o=1 are dropped. Storage is retained across
//   runs; a run does not modify it.
//  FSM: IDLE -start_i-> CLEAR (1 cyc) -> STREAM (7 cyc, t=0..6) ->
//   FLUSH (FLUSH_CYCLES cyc) -> DONE (1 cyc) -> IDLE.
//   start_i ignored outside IDLE; start_i in the DONE cycle ignored.
//   Same-cycle wr_en_i and start_i in IDLE: write lands, run uses new value.
//  All outputs registered. busy_o=1 in CLEAR, STREAM, FLUSH; done_o=1 in DONE.
//  CLEAR: array_rst_no=0 for exactly one cycle; streams = 0.
//  STREAM beat t (t-th cycle of STREAM, outputs valid that cycle):
//   left_o_r = A[r][t-r] if 0 <= t-r <= 3, else 0
//   up_o_c   = B[t-c][c] if 0 <= t-c <= 3, else 0
//  Outside STREAM all left/up outputs = 0 (zeros into PEs are harmless MACs).
//  Timing: start accepted at edge E0 -> CLEAR cycle after E0, first beat 1 cyc
//   later, done_o high 1+7+FLUSH_CYCLES cycles after CLEAR (12 at default),
//   i.e. 11 cycles after first beat, matching array fill+drain of 10 + 1.
//  No arithmetic: elements pass through unmodified, width DW, no sign handling.
// TESTING
//  1 Load A=I, B[k][c]=4k+c+1; start -> left_o_0 beats 1,0,0,0,0,0,0;
//    up_o_1 beats 0,2,6,10,14,0,0; up_o_3 beats 0,0,0,4,8,12,16.
//  2 Same load; count cycles -> array_rst_no low 1 cyc, done_o 1-cyc pulse
//    exactly 12 cycles after CLEAR; with array attached C equals B.
//  3 start_i and wr_en_i (A[0]=0xDEAD) asserted during STREAM -> no restart,
//    beat sequence unchanged, A[0] unchanged on next run.
//  4 rst_i pulsed at STREAM t=3 -> same cycle all streams 0, busy_o=0,
//    array_rst_no=0; rerun with no writes -> all beats 0.
//  5 start_i held high continuously -> runs back-to-back with one IDLE cycle
//    between DONE and next CLEAR; each run identical.
//  6 FLUSH_CYCLES=0 -> done_o 8 cycles after CLEAR, beat timing unchanged.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Host/load side bundle of the systolic feeder: matrix write port, run
// control and the skewed edge streams that go to the 4x4 array.
interface systolic_feeder_if #(
  parameter int DW = 32
);
  logic          wr_en_i;
  logic          wr_sel_i;
  logic [3:0]    wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          array_rst_no;
  logic [DW-1:0] left_o_0, left_o_1, left_o_2, left_o_3;
  logic [DW-1:0] up_o_0, up_o_1, up_o_2, up_o_3;

  // Host / load logic side
  modport master (
    output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    input  busy_o, done_o, array_rst_no,
    input  left_o_0, left_o_1, left_o_2, left_o_3,
    input  up_o_0, up_o_1, up_o_2, up_o_3
  );

  // Feeder side
  modport slave (
    input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    output busy_o, done_o, array_rst_no,
    output left_o_0, left_o_1, left_o_2, left_o_3,
    output up_o_0, up_o_1, up_o_2, up_o_3
  );
endinterface

// File: rtl/systolic_feeder.sv
// Edge feeder for a 4x4 systolic multiplier. Stores A and B, clears the
// array, streams diagonally skewed A rows (left edge) and B columns (top
// edge), waits for the pipeline to drain and pulses done_o.
// Every output is a flop loaded from a decode of the *next* state, so the
// registered outputs line up exactly with the state they describe.
module systolic_feeder #(
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  systolic_feeder_if.slave bus
);
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_FLUSH, ST_DONE} state_t;

  localparam int STREAM_LAST = 6;
  localparam int CNT_MAX     = (FLUSH_CYCLES > STREAM_LAST) ? FLUSH_CYCLES : STREAM_LAST;
  localparam int CW          = $clog2(CNT_MAX + 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0][DW-1:0]    a_q, a_d, b_q, b_d;
  logic                   busy_q, busy_d, done_q, done_d, arst_n_q, arst_n_d;
  logic [3:0][DW-1:0]     left_q, left_d, up_q, up_d;

  // Element writes, only while idle; a run never touches storage
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (bus.wr_en_i && state_q == ST_IDLE) begin
      if (bus.wr_sel_i) b_d[bus.wr_addr_i] = bus.wr_data_i;
      else              a_d[bus.wr_addr_i] = bus.wr_data_i;
    end
  end

  // Sequencer: IDLE -> CLEAR -> STREAM(7) -> FLUSH(N) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d = ST_STREAM;
        cnt_d   = '0;
      end
      ST_STREAM: begin
        if (cnt_q == CW'(STREAM_LAST)) begin
          cnt_d   = '0;
          state_d = (FLUSH_CYCLES == 0) ? ST_DONE : ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CW'(FLUSH_CYCLES - 1)) state_d = ST_DONE;
        else                                cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state; beat t = cnt_d while streaming
  always_comb begin
    busy_d   = (state_d == ST_CLEAR) || (state_d == ST_STREAM) || (state_d == ST_FLUSH);
    done_d   = (state_d == ST_DONE);
    arst_n_d = (state_d != ST_CLEAR);
    left_d   = '0;
    up_d     = '0;
    if (state_d == ST_STREAM) begin
      for (int l = 0; l < 4; l++) begin
        if (int'(cnt_d) >= l && int'(cnt_d) <= l + 3) begin
          left_d[l] = a_q[4'(l * 4 + int'(cnt_d) - l)];
          up_d[l]   = b_q[4'((int'(cnt_d) - l) * 4 + l)];
        end
      end
    end
  end

  // State, storage and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      arst_n_q <= 1'b0;
      left_q   <= '0;
      up_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      arst_n_q <= arst_n_d;
      left_q   <= left_d;
      up_q     <= up_d;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.array_rst_no = arst_n_q;
  assign bus.left_o_0     = left_q[0];
  assign bus.left_o_1     = left_q[1];
  assign bus.left_o_2     = left_q[2];
  assign bus.left_o_3     = left_q[3];
  assign bus.up_o_0       = up_q[0];
  assign bus.up_o_1       = up_q[1];
  assign bus.up_o_2       = up_q[2];
  assign bus.up_o_3       = up_q[3];
endmodule
